// File: rtl/peripheral_share_pkg.sv
// Shared types and helpers for the parent-resource sharing block.
// Imported by the per-child handshake FSM and by the top level.
package peripheral_share_pkg;

  typedef enum logic [2:0] {IDLE, WAKE, ON, HOLD, SLEEP} parent_state_t;
  typedef enum logic [1:0] {SILENT, STARTING, READY, STOPPING} child_state_t;

  // Width of the hold counter; never narrower than one bit.
  function automatic int hold_count_width(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // One-hot status vector ordered {stopping, ready, starting, silent}.
  function automatic logic [3:0] child_status(input child_state_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/peripheral_share_child.sv
// Per-consumer handshake FSM: turns a level request plus the shared
// parent status into a one-hot silent/starting/ready/stopping view.
module peripheral_share_child
  import peripheral_share_pkg::*;
(
  input  logic clock,
  input  logic async_resetn,
  input  logic request,
  input  logic parent_up,
  output logic silent,
  output logic starting,
  output logic ready,
  output logic stopping,
  output logic active
);

  child_state_t state;
  logic [3:0]   status;

  // Losing the parent while READY demotes the child back to STARTING.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state  <= SILENT;
      status <= child_status(SILENT);
    end else begin
      case (state)
        SILENT: begin
          if (request) begin
            state  <= STARTING;
            status <= child_status(STARTING);
          end
        end
        STARTING: begin
          if (!request) begin
            state  <= STOPPING;
            status <= child_status(STOPPING);
          end else if (parent_up) begin
            state  <= READY;
            status <= child_status(READY);
          end
        end
        READY: begin
          if (!request) begin
            state  <= STOPPING;
            status <= child_status(STOPPING);
          end else if (!parent_up) begin
            state  <= STARTING;
            status <= child_status(STARTING);
          end
        end
        STOPPING: begin
          state  <= SILENT;
          status <= child_status(SILENT);
        end
        default: begin
          state  <= SILENT;
          status <= child_status(SILENT);
        end
      endcase
    end
  end

  assign {stopping, ready, starting, silent} = status;
  assign active = starting | ready;

endmodule

// File: rtl/peripheral_share_parent.sv
// Shares one upstream clock/power provider between NUM_CHILD consumers,
// holding the upstream request for HOLD_CYCLES after the last one leaves.
module peripheral_share_parent
  import peripheral_share_pkg::*;
#(
  parameter int NUM_CHILD   = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 async_resetn,
  input  logic [NUM_CHILD-1:0] child_request,
  output logic [NUM_CHILD-1:0] child_ready,
  output logic [NUM_CHILD-1:0] child_silent,
  output logic [NUM_CHILD-1:0] child_starting,
  output logic [NUM_CHILD-1:0] child_stopping,
  output logic                 parent_request,
  input  logic                 parent_ready,
  input  logic                 parent_silent,
  input  logic                 parent_starting,
  input  logic                 parent_stopping,
  output logic                 fault
);

  localparam int CW = hold_count_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  parent_state_t        state;
  logic [CW-1:0]        hold_count;
  logic [NUM_CHILD-1:0] child_active;
  logic                 any_request;
  logic                 any_active;
  logic                 parent_up;
  logic                 unused_status;

  assign any_request   = |child_request;
  assign any_active    = |child_active;
  assign unused_status = parent_starting ^ parent_stopping;

  // WAKE counts as up so a child goes ready the cycle after parent_ready
  // is first seen, in step with the parent FSM entering ON.
  assign parent_up = parent_ready && (state == WAKE || state == ON || state == HOLD);

  for (genvar i = 0; i < NUM_CHILD; i++) begin : g_child
    peripheral_share_child u_child (
      .clock        (clock),
      .async_resetn (async_resetn),
      .request      (child_request[i]),
      .parent_up    (parent_up),
      .silent       (child_silent[i]),
      .starting     (child_starting[i]),
      .ready        (child_ready[i]),
      .stopping     (child_stopping[i]),
      .active       (child_active[i])
    );
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state          <= IDLE;
      parent_request <= 1'b0;
      fault          <= 1'b0;
      hold_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_request) begin
            state          <= WAKE;
            parent_request <= 1'b1;
          end
        end
        WAKE: begin
          if (parent_ready) begin
            state <= ON;
          end
        end
        ON: begin
          if (!parent_ready) begin
            state <= WAKE;
            fault <= 1'b1;
          end else if (!any_active) begin
            if (HOLD_CYCLES == 0) begin
              state          <= SLEEP;
              parent_request <= 1'b0;
            end else begin
              state      <= HOLD;
              hold_count <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          // A request arriving as the count expires still wins.
          if (!parent_ready) begin
            state      <= WAKE;
            fault      <= 1'b1;
            hold_count <= '0;
          end else if (any_request) begin
            state      <= ON;
            hold_count <= '0;
          end else if (hold_count == '0) begin
            state          <= SLEEP;
            parent_request <= 1'b0;
          end else begin
            hold_count <= hold_count - CW'(1);
          end
        end
        SLEEP: begin
          // Never re-request until the provider has actually gone silent.
          if (parent_silent) begin
            if (any_request) begin
              state          <= WAKE;
              parent_request <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state          <= IDLE;
          parent_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_share_parent.sv
// Randomised self-checking bench for peripheral_share_parent with a
// behavioural model of the sharing rules plus directed literal checks.
module tb_peripheral_share_parent;

  localparam int NC   = 4;
  localparam int HOLD = 4;

  localparam int M_IDLE = 0, M_WAKE = 1, M_ON = 2, M_HOLD = 3, M_SLEEP = 4;
  localparam int K_SILENT = 0, K_STARTING = 1, K_READY = 2, K_STOPPING = 3;

  logic          clock;
  logic          async_resetn;
  logic [NC-1:0] child_request;
  logic [NC-1:0] child_ready;
  logic [NC-1:0] child_silent;
  logic [NC-1:0] child_starting;
  logic [NC-1:0] child_stopping;
  logic          parent_request;
  logic          parent_ready;
  logic          parent_silent;
  logic          parent_starting;
  logic          parent_stopping;
  logic          fault;

  int checks = 0;
  int errors = 0;

  int m_phase;
  int m_hold_elapsed;
  int m_kid[NC];
  bit m_fault;

  peripheral_share_parent #(.NUM_CHILD(NC), .HOLD_CYCLES(HOLD)) dut (
    .clock           (clock),
    .async_resetn    (async_resetn),
    .child_request   (child_request),
    .child_ready     (child_ready),
    .child_silent    (child_silent),
    .child_starting  (child_starting),
    .child_stopping  (child_stopping),
    .parent_request  (parent_request),
    .parent_ready    (parent_ready),
    .parent_silent   (parent_silent),
    .parent_starting (parent_starting),
    .parent_stopping (parent_stopping),
    .fault           (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] req, input logic rdy, input logic sil,
                               input logic sta, input logic sto);
    child_request   = req;
    parent_ready    = rdy;
    parent_silent   = sil;
    parent_starting = sta;
    parent_stopping = sto;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Behavioural reference: one step of the sharing rules per clock.
  task automatic modelStep();
    int  nk[NC];
    int  n_active;
    bit  any_req;
    bit  up;
    any_req  = (child_request != '0);
    n_active = 0;
    foreach (m_kid[i]) if (m_kid[i] == K_STARTING || m_kid[i] == K_READY) n_active++;
    up = parent_ready && (m_phase == M_WAKE || m_phase == M_ON || m_phase == M_HOLD);
    foreach (m_kid[i]) begin
      nk[i] = m_kid[i];
      if (m_kid[i] == K_SILENT)        nk[i] = child_request[i] ? K_STARTING : K_SILENT;
      else if (m_kid[i] == K_STOPPING) nk[i] = K_SILENT;
      else if (!child_request[i])      nk[i] = K_STOPPING;
      else                             nk[i] = up ? K_READY : K_STARTING;
    end
    if (m_phase == M_IDLE) begin
      if (any_req) m_phase = M_WAKE;
    end else if (m_phase == M_WAKE) begin
      if (parent_ready) m_phase = M_ON;
    end else if (m_phase == M_ON || m_phase == M_HOLD) begin
      if (!parent_ready) begin
        m_fault = 1'b1;
        m_phase = M_WAKE;
      end else if (m_phase == M_ON) begin
        if (n_active == 0) begin
          m_phase        = (HOLD == 0) ? M_SLEEP : M_HOLD;
          m_hold_elapsed = 1;
        end
      end else if (any_req) begin
        m_phase = M_ON;
      end else if (m_hold_elapsed >= HOLD) begin
        m_phase = M_SLEEP;
      end else begin
        m_hold_elapsed++;
      end
    end else if (m_phase == M_SLEEP) begin
      if (parent_silent) m_phase = any_req ? M_WAKE : M_IDLE;
    end
    foreach (m_kid[i]) m_kid[i] = nk[i];
  endtask

  always @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      m_phase        = M_IDLE;
      m_hold_elapsed = 0;
      m_fault        = 1'b0;
      foreach (m_kid[i]) m_kid[i] = K_SILENT;
    end else begin
      modelStep();
    end
  end

  // Every falling edge compares all outputs with the model.
  always @(negedge clock) begin
    logic [NC-1:0] e_rdy, e_sil, e_sta, e_sto;
    logic          e_pr;
    for (int i = 0; i < NC; i++) begin
      e_rdy[i] = (m_kid[i] == K_READY);
      e_sil[i] = (m_kid[i] == K_SILENT);
      e_sta[i] = (m_kid[i] == K_STARTING);
      e_sto[i] = (m_kid[i] == K_STOPPING);
    end
    e_pr = (m_phase == M_WAKE || m_phase == M_ON || m_phase == M_HOLD);
    checkOutput("model parent_request", parent_request, e_pr);
    checkOutput("model fault", fault, m_fault);
    checkOutput("model child_ready", child_ready, e_rdy);
    checkOutput("model child_silent", child_silent, e_sil);
    checkOutput("model child_starting", child_starting, e_sta);
    checkOutput("model child_stopping", child_stopping, e_sto);
    for (int i = 0; i < NC; i++)
      checkOutput("onehot status", $countones({child_silent[i], child_starting[i],
                                               child_ready[i], child_stopping[i]}), 1);
  end

  initial begin
    logic [NC-1:0] req;
    int prov;
    int pdelay;

    applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
    async_resetn = 1'b0;
    tick();
    tick();
    checkOutput("reset parent_request", parent_request, 0);
    checkOutput("reset child_silent", child_silent, 4'hF);
    checkOutput("reset child_ready", child_ready, 0);
    checkOutput("reset child_starting", child_starting, 0);
    checkOutput("reset child_stopping", child_stopping, 0);
    checkOutput("reset fault", fault, 0);
    #2 async_resetn = 1'b1;
    tick();

    // Single child wakes the parent.
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("wake parent_request", parent_request, 1);
    checkOutput("wake child_starting", child_starting, 4'b0001);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("wake not yet ready", child_ready, 0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("wake child_ready", child_ready, 4'b0001);

    // Release and hold for exactly HOLD cycles.
    repeat (4) tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("release stopping", child_stopping, 4'b0001);
    tick();
    checkOutput("release silent", child_silent, 4'hF);
    for (int k = 0; k < HOLD; k++) begin
      checkOutput("hold parent_request", parent_request, 1);
      tick();
    end
    checkOutput("hold expired", parent_request, 0);

    // Request during SLEEP waits for parent_silent.
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("sleep parent_request", parent_request, 0);
      checkOutput("sleep child_starting", child_starting, 4'b0010);
    end
    applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("sleep rewake", parent_request, 1);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rewake ready", child_ready, 4'b0010);

    // Request while the hold counter reads one.
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("hold rejoin parent_request", parent_request, 1);
    end
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rejoin starting", child_starting, 4'b0100);
    checkOutput("rejoin parent_request", parent_request, 1);
    tick();
    checkOutput("rejoin ready", child_ready, 4'b0100);

    // Two ready children, then the provider drops out unrequested.
    applyStimulus(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("two ready", child_ready, 4'b1100);
    applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("fault set", fault, 1);
    checkOutput("fault demote", child_starting, 4'b1100);
    checkOutput("fault ready cleared", child_ready, 0);
    applyStimulus(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("fault sticky", fault, 1);
    checkOutput("fault recover", child_ready, 4'b1100);
    #1 async_resetn = 1'b0;
    #1;
    checkOutput("async reset fault", fault, 0);
    checkOutput("async reset silent", child_silent, 4'hF);
    checkOutput("async reset parent_request", parent_request, 0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 async_resetn = 1'b1;
    tick();

    // All children together: one rise, ready together.
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("all parent_request", parent_request, 1);
    checkOutput("all starting", child_starting, 4'hF);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("all held", parent_request, 1);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("all ready", child_ready, 4'hF);

    // Random traffic against a behavioural provider.
    req    = 4'b1111;
    prov   = 2;
    pdelay = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int i = 0; i < NC; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b1;
        end
      end
      case (prov)
        0: if (parent_request) begin prov = 1; pdelay = $urandom_range(1, 4); end
        1: if (pdelay == 0) prov = 2; else pdelay--;
        2: if (!parent_request || $urandom_range(0, 199) == 0) begin
             prov = 3;
             pdelay = $urandom_range(1, 3);
           end
        default: if (pdelay == 0) prov = 0; else pdelay--;
      endcase
      applyStimulus(req, prov == 2, prov == 0, prov == 1, prov == 3);
      if ($urandom_range(0, 999) == 0) begin
        #1 async_resetn = 1'b0;
        #1 async_resetn = 1'b1;
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
